// File: rtl/cpu65_pkg.sv
// Shared types for the 6502-style address path: addressing mode and the
// indexed-address FSM state encoding.
package cpu65_pkg;

    typedef enum logic {
        ZPG_IDX = 1'b0,
        ABS_IDX = 1'b1
    } mode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        FIXUP    = 3'd3,
        DONE     = 3'd4
    } agen_state_t;

endpackage

// File: rtl/index_address_generator.sv
// Indexed effective-address generator (zp,X / abs,X|Y) with the 6502-style
// uncorrected dummy read on page cross or store.
module index_address_generator
    import cpu65_pkg::*;
(
    input  logic        fclk,
    input  logic        reset,
    input  logic        start,
    input  mode_t       mode,
    input  logic        is_write,
    input  logic [7:0]  index_in,
    input  logic [7:0]  db_in,
    input  logic        db_valid,
    output logic [15:0] ab_out,
    output logic        addr_valid,
    output logic        dummy_cycle,
    output logic        page_cross,
    output logic        busy
);

    agen_state_t r_state, w_state_next;
    mode_t       r_mode, w_mode_next;
    logic        r_is_write, w_is_write_next;
    logic [7:0]  r_index, w_index_next;
    logic [7:0]  r_hi, w_hi_next;
    logic [8:0]  r_sum9, w_sum9_next;
    logic [15:0] r_ab, w_ab_next;
    logic        r_addr_valid, w_addr_valid_next;
    logic        r_dummy, w_dummy_next;
    logic        r_page_cross, w_page_cross_next;
    logic        r_busy, w_busy_next;
    logic [8:0]  w_sum9;

    assign w_sum9 = {1'b0, db_in} + {1'b0, r_index};

    always_comb begin
        w_state_next      = r_state;
        w_mode_next       = r_mode;
        w_is_write_next   = r_is_write;
        w_index_next      = r_index;
        w_hi_next         = r_hi;
        w_sum9_next       = r_sum9;
        w_ab_next         = r_ab;
        w_addr_valid_next = 1'b0;
        w_dummy_next      = 1'b0;
        w_page_cross_next = r_page_cross;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mode_next       = mode;
                    w_is_write_next   = is_write;
                    w_index_next      = index_in;
                    w_page_cross_next = 1'b0;
                    w_state_next      = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (db_valid) begin
                    w_sum9_next = w_sum9;
                    if (r_mode == ZPG_IDX) begin
                        // Zero page wraps: the carry never reaches the high byte.
                        w_ab_next         = {8'h00, w_sum9[7:0]};
                        w_addr_valid_next = 1'b1;
                        w_state_next      = DONE;
                    end else begin
                        w_state_next = FETCH_HI;
                    end
                end
            end
            FETCH_HI: begin
                if (db_valid) begin
                    w_hi_next         = db_in;
                    w_page_cross_next = r_sum9[8];
                    w_ab_next         = {db_in, r_sum9[7:0]};
                    if (r_sum9[8] || r_is_write) begin
                        w_dummy_next = 1'b1;
                        w_state_next = FIXUP;
                    end else begin
                        w_addr_valid_next = 1'b1;
                        w_state_next      = DONE;
                    end
                end
            end
            FIXUP: begin
                w_ab_next         = {r_hi + {7'b0, r_sum9[8]}, r_sum9[7:0]};
                w_addr_valid_next = 1'b1;
                w_state_next      = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mode       <= ZPG_IDX;
            r_is_write   <= 1'b0;
            r_index      <= 8'h00;
            r_hi         <= 8'h00;
            r_sum9       <= 9'h000;
            r_ab         <= 16'h0000;
            r_addr_valid <= 1'b0;
            r_dummy      <= 1'b0;
            r_page_cross <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mode       <= w_mode_next;
            r_is_write   <= w_is_write_next;
            r_index      <= w_index_next;
            r_hi         <= w_hi_next;
            r_sum9       <= w_sum9_next;
            r_ab         <= w_ab_next;
            r_addr_valid <= w_addr_valid_next;
            r_dummy      <= w_dummy_next;
            r_page_cross <= w_page_cross_next;
            r_busy       <= w_busy_next;
        end
    end

    assign ab_out      = r_ab;
    assign addr_valid  = r_addr_valid;
    assign dummy_cycle = r_dummy;
    assign page_cross  = r_page_cross;
    assign busy        = r_busy;

endmodule

// File: tb/tb_index_address_generator.sv
// Directed bench for index_address_generator: each scenario task drives its
// vectors and compares against hand-computed addresses and flags.
module tb_index_address_generator;
    import cpu65_pkg::*;

    logic        fclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    mode_t       mode = ZPG_IDX;
    logic        is_write = 1'b0;
    logic [7:0]  index_in = 8'h00;
    logic [7:0]  db_in = 8'h00;
    logic        db_valid = 1'b0;
    logic [15:0] ab_out;
    logic        addr_valid;
    logic        dummy_cycle;
    logic        page_cross;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    index_address_generator dut (
        .fclk        (fclk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .is_write    (is_write),
        .index_in    (index_in),
        .db_in       (db_in),
        .db_valid    (db_valid),
        .ab_out      (ab_out),
        .addr_valid  (addr_valid),
        .dummy_cycle (dummy_cycle),
        .page_cross  (page_cross),
        .busy        (busy)
    );

    always #5 fclk = ~fclk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic do_start(input mode_t m, input logic w, input logic [7:0] idx);
        start = 1'b1; mode = m; is_write = w; index_in = idx;
        step();
        start = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            db_valid = 1'b0;
            step();
        end
        db_valid = 1'b1; db_in = b;
        step();
        db_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++; if (ab_out !== 16'h0000) begin n_mis++; $display("FAIL reset_ab: got %h need 0000", ab_out); end
        n_cmp++; if ({addr_valid, dummy_cycle, page_cross, busy} !== 4'b0000) begin n_mis++; $display("FAIL reset_flags: got %b need 0000", {addr_valid, dummy_cycle, page_cross, busy}); end
        db_valid = 1'b1; db_in = 8'hAA;
        step();
        db_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || ab_out !== 16'h0000) begin n_mis++; $display("FAIL idle_ignores_db: busy %b ab %h need 0 0000", busy, ab_out); end
        $display("reset: ab=%h busy=%b", ab_out, busy);
    endtask

    task automatic test_zpg_wrap();
        do_start(ZPG_IDX, 1'b1, 8'h20);
        n_cmp++; if (busy !== 1'b1 || addr_valid !== 1'b0) begin n_mis++; $display("FAIL zpg_busy: busy %b av %b need 1 0", busy, addr_valid); end
        feed_byte(8'hF0, 0);
        n_cmp++; if (ab_out !== 16'h0010) begin n_mis++; $display("FAIL zpg_ab: got %h need 0010", ab_out); end
        n_cmp++; if ({addr_valid, dummy_cycle, page_cross} !== 3'b100) begin n_mis++; $display("FAIL zpg_flags: av/dc/pc got %b need 100", {addr_valid, dummy_cycle, page_cross}); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if ({addr_valid, dummy_cycle, busy} !== 3'b000) begin n_mis++; $display("FAIL done_ignores_start: av/dc/busy got %b need 000", {addr_valid, dummy_cycle, busy}); end
        n_cmp++; if (ab_out !== 16'h0010) begin n_mis++; $display("FAIL zpg_hold: got %h need 0010", ab_out); end
        $display("zpg wrap: ab=%h", ab_out);
    endtask

    task automatic test_abs_read_no_cross();
        do_start(ABS_IDX, 1'b0, 8'h10);
        feed_byte(8'h34, 0);
        n_cmp++; if (addr_valid !== 1'b0 || dummy_cycle !== 1'b0 || ab_out !== 16'h0010) begin n_mis++; $display("FAIL abs_hold_fetch_hi: av %b dc %b ab %h need 0 0 0010", addr_valid, dummy_cycle, ab_out); end
        feed_byte(8'h12, 0);
        n_cmp++; if (ab_out !== 16'h1244 || addr_valid !== 1'b1) begin n_mis++; $display("FAIL abs_nocross: ab %h av %b need 1244 1", ab_out, addr_valid); end
        n_cmp++; if (dummy_cycle !== 1'b0 || page_cross !== 1'b0) begin n_mis++; $display("FAIL abs_nocross_flags: dc %b pc %b need 0 0", dummy_cycle, page_cross); end
        step();
        n_cmp++; if (busy !== 1'b0 || addr_valid !== 1'b0) begin n_mis++; $display("FAIL abs_nocross_idle: busy %b av %b need 0 0", busy, addr_valid); end
        $display("abs read no cross: ab=%h", ab_out);
    endtask

    task automatic test_abs_read_cross();
        do_start(ABS_IDX, 1'b0, 8'h20);
        feed_byte(8'hF0, 0);
        feed_byte(8'h12, 0);
        n_cmp++; if (ab_out !== 16'h1210 || dummy_cycle !== 1'b1 || addr_valid !== 1'b0) begin n_mis++; $display("FAIL cross_fixup: ab %h dc %b av %b need 1210 1 0", ab_out, dummy_cycle, addr_valid); end
        n_cmp++; if (page_cross !== 1'b1) begin n_mis++; $display("FAIL cross_pc_fixup: got %b need 1", page_cross); end
        step();
        n_cmp++; if (ab_out !== 16'h1310 || addr_valid !== 1'b1 || dummy_cycle !== 1'b0) begin n_mis++; $display("FAIL cross_done: ab %h av %b dc %b need 1310 1 0", ab_out, addr_valid, dummy_cycle); end
        n_cmp++; if (page_cross !== 1'b1) begin n_mis++; $display("FAIL cross_pc_done: got %b need 1", page_cross); end
        step();
        $display("abs read cross: ab=%h", ab_out);
    endtask

    task automatic test_abs_write();
        do_start(ABS_IDX, 1'b1, 8'h05);
        feed_byte(8'h00, 0);
        feed_byte(8'h20, 0);
        n_cmp++; if (ab_out !== 16'h2005 || dummy_cycle !== 1'b1 || page_cross !== 1'b0) begin n_mis++; $display("FAIL write_fixup: ab %h dc %b pc %b need 2005 1 0", ab_out, dummy_cycle, page_cross); end
        step();
        n_cmp++; if (ab_out !== 16'h2005 || addr_valid !== 1'b1 || dummy_cycle !== 1'b0) begin n_mis++; $display("FAIL write_done: ab %h av %b dc %b need 2005 1 0", ab_out, addr_valid, dummy_cycle); end
        step();
        $display("abs write: ab=%h", ab_out);
    endtask

    task automatic test_wrap16();
        do_start(ABS_IDX, 1'b0, 8'h01);
        feed_byte(8'hFF, 0);
        feed_byte(8'hFF, 0);
        n_cmp++; if (ab_out !== 16'hFF00 || dummy_cycle !== 1'b1 || page_cross !== 1'b1) begin n_mis++; $display("FAIL wrap_fixup: ab %h dc %b pc %b need ff00 1 1", ab_out, dummy_cycle, page_cross); end
        step();
        n_cmp++; if (ab_out !== 16'h0000 || addr_valid !== 1'b1) begin n_mis++; $display("FAIL wrap_done: ab %h av %b need 0000 1", ab_out, addr_valid); end
        step();
        $display("16-bit wrap: ab=%h", ab_out);
    endtask

    task automatic test_reset_mid_op();
        do_start(ABS_IDX, 1'b0, 8'h10);
        feed_byte(8'h34, 0);
        reset = 1'b1; start = 1'b1; db_valid = 1'b1; db_in = 8'h12;
        step();
        reset = 1'b0; start = 1'b0; db_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || ab_out !== 16'h0000) begin n_mis++; $display("FAIL midop_reset: busy %b ab %h need 0 0000", busy, ab_out); end
        n_cmp++; if ({addr_valid, dummy_cycle, page_cross} !== 3'b000) begin n_mis++; $display("FAIL midop_reset_flags: got %b need 000", {addr_valid, dummy_cycle, page_cross}); end
        do_start(ABS_IDX, 1'b0, 8'h10);
        feed_byte(8'h34, 0);
        feed_byte(8'h12, 0);
        n_cmp++; if (ab_out !== 16'h1244 || addr_valid !== 1'b1) begin n_mis++; $display("FAIL after_reset: ab %h av %b need 1244 1", ab_out, addr_valid); end
        step();
        $display("reset mid-op then abs: ab=%h", ab_out);
    endtask

    task automatic test_gaps();
        do_start(ABS_IDX, 1'b0, 8'h10);
        feed_byte(8'h34, 3);
        n_cmp++; if (busy !== 1'b1 || addr_valid !== 1'b0) begin n_mis++; $display("FAIL gap_lo: busy %b av %b need 1 0", busy, addr_valid); end
        feed_byte(8'h12, 3);
        n_cmp++; if (ab_out !== 16'h1244 || addr_valid !== 1'b1) begin n_mis++; $display("FAIL gap_nocross: ab %h av %b need 1244 1", ab_out, addr_valid); end
        step();
        do_start(ABS_IDX, 1'b0, 8'h20);
        start = 1'b1;
        feed_byte(8'hF0, 3);
        start = 1'b0;
        feed_byte(8'h12, 3);
        n_cmp++; if (ab_out !== 16'h1210 || dummy_cycle !== 1'b1) begin n_mis++; $display("FAIL gap_fixup: ab %h dc %b need 1210 1", ab_out, dummy_cycle); end
        step();
        n_cmp++; if (ab_out !== 16'h1310 || addr_valid !== 1'b1 || page_cross !== 1'b1) begin n_mis++; $display("FAIL gap_cross: ab %h av %b pc %b need 1310 1 1", ab_out, addr_valid, page_cross); end
        step();
        $display("gapped fetches: ab=%h", ab_out);
    endtask

    always @(negedge fclk) begin
        if (addr_valid === 1'b1 && dummy_cycle === 1'b1) begin
            n_mis++;
            $display("FAIL av_dc_exclusive: both high at %0t", $time);
        end
    end

    initial begin
        test_reset();
        test_zpg_wrap();
        test_abs_read_no_cross();
        test_abs_read_cross();
        test_abs_write();
        test_wrap16();
        test_reset_mid_op();
        test_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/index_address_generator.md
INDEX_ADDRESS_GENERATOR -- requirements
Module: index_address_generator

Interface
REQ-001 SHALL have port fclk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising fclk.
REQ-003 SHALL have port start, input, 1 bit: begin an address computation; honoured only in IDLE.
REQ-004 SHALL have port mode, input, 1 bit (mode_t): ZPG_IDX (one base byte) or ABS_IDX (two base bytes, low byte first); sampled with start.
REQ-005 SHALL have port is_write, input, 1 bit: access is a store or RMW, which forces a fixup cycle; sampled with start.
REQ-006 SHALL have port index_in, input, 8 bits: X or Y index register value; sampled with start.
REQ-007 SHALL have port db_in, input, 8 bits: operand byte from the data bus.
REQ-008 SHALL have port db_valid, input, 1 bit: db_in holds the next operand byte this cycle.
REQ-009 SHALL have port ab_out, output, 16 bits: effective or dummy address.
REQ-010 SHALL have port addr_valid, output, 1 bit: ab_out holds the final effective address (one-cycle pulse).
REQ-011 SHALL have port dummy_cycle, output, 1 bit: ab_out holds the uncorrected dummy-read address.
REQ-012 SHALL have port page_cross, output, 1 bit: carry out of the low-byte add; held from FETCH_HI completion through DONE.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH_LO, FETCH_HI, FIXUP and DONE; all outputs SHALL be registered.
REQ-015 IDLE: on start=1, latch mode, is_write and index_in, clear page_cross, then go to FETCH_LO.
REQ-016 FETCH_LO: stay while db_valid=0; on db_valid=1, latch sum9 = {0,db_in} + {0,index}.
REQ-017 FETCH_LO with ZPG_IDX: go to DONE with final address {8'h00, sum9[7:0]}; the carry SHALL be discarded (zero-page wrap); page_cross SHALL stay 0; no fixup cycle, even when is_write=1.
REQ-018 FETCH_LO with ABS_IDX: go to FETCH_HI.
REQ-019 FETCH_HI: stay while db_valid=0; on db_valid=1, latch hi = db_in and set page_cross = sum9[8].
REQ-020 FETCH_HI exit: go to FIXUP if sum9[8]=1 or is_write=1; otherwise go to DONE with ab_out = {hi, sum9[7:0]}.
REQ-021 FIXUP lasts exactly one cycle: ab_out = {hi, sum9[7:0]} (uncorrected) and dummy_cycle=1; then go to DONE.
REQ-022 In DONE, ab_out SHALL be {hi + sum9[8], sum9[7:0]} using mod-256 high-byte arithmetic, so 0xFF+1 wraps to 0x00 and the 16-bit result wraps 0xFFFF to 0x0000.
REQ-023 DONE lasts one cycle with addr_valid=1, then returns to IDLE.
REQ-024 A start asserted in DONE SHALL be ignored; the next computation begins no earlier than the cycle after IDLE is re-entered.
REQ-025 Latency from the registering edge of the final operand byte to addr_valid: 1 cycle without fixup, 2 cycles with fixup.
REQ-026 start asserted in any non-IDLE state SHALL be ignored.
REQ-027 db_valid SHALL be ignored in IDLE, FIXUP and DONE.
REQ-028 addr_valid and dummy_cycle SHALL never be high together.
REQ-029 ab_out SHALL hold its last value while waiting in IDLE, FETCH_LO and FETCH_HI.

Reset
REQ-030 reset=1 SHALL force IDLE regardless of state, including mid-operation, and SHALL take priority over start and db_valid.
REQ-031 On reset: ab_out=16'h0000; addr_valid, dummy_cycle, page_cross and busy =0; latched index, base bytes and sum cleared to 0.

Structure
REQ-032 mode_t and the FSM state enum SHALL reside in the shared package cpu65_pkg.
REQ-033 SHALL be a single flat module; no sub-module is required, and the 9-bit add SHALL be inline.

Verification
REQ-034 ZPG wrap: start, ZPG_IDX, index 0x20, byte 0xF0 -> ab_out=0x0010, addr_valid one cycle after the byte, page_cross=0, dummy_cycle never high.
REQ-035 ABS read, no page cross: index 0x10, bytes 0x34 then 0x12 -> no FIXUP, ab_out=0x1244, addr_valid 1 cycle after the high byte.
REQ-036 ABS read, page cross: index 0x20, bytes 0xF0 then 0x12 -> FIXUP cycle with ab_out=0x1210 and dummy_cycle=1, then DONE with ab_out=0x1310, page_cross=1.
REQ-037 ABS write, no cross: is_write=1, index 0x05, bytes 0x00 then 0x20 -> dummy 0x2005, then final 0x2005, page_cross=0.
REQ-038 16-bit wrap: index 0x01, bytes 0xFF then 0xFF -> dummy 0xFF00, final 0x0000, page_cross=1.
REQ-039 Reset mid-op: assert reset in FETCH_HI after low byte 0x34 -> next cycle busy=0 and all outputs 0; a following computation (0x1234 + 0x10) yields 0x1244; db_valid gaps of 3 cycles in each fetch state -> same results, delayed accordingly.
